// File: rtl/scope_trigger_capture.sv
// Scope sample capture: circular pre-trigger history, slope trigger, fixed post window,
// then a frozen trace read back by trigger-relative address with one cycle of latency.
`timescale 1ns/1ps
module scope_trigger_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int PRE    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              force_trig,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              armed,
    output logic              triggered,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  PRE_CNT  = CNT_W'(PRE);
    localparam logic [CNT_W-1:0]  POST_CNT = CNT_W'(DEPTH - PRE);
    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, start_ptr, rd_idx;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              capturing, accept, trig_hit;

    function automatic logic level_cross(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] s,
                                         input logic [DATA_W-1:0] lvl, input logic rising);
        if (rising)
            return (p < lvl) && (s >= lvl);
        else
            return (p >= lvl) && (s < lvl);
    endfunction

    always_comb begin
        capturing = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
        // arm takes priority: a sample arriving with it is dropped
        accept    = capturing && ena && sample_valid && !arm;
        trig_hit  = accept && (state == S_ARMED) &&
                    (force_trig || (prev_valid && level_cross(prev, sample_in, trig_level, trig_rising)));
        cnt_inc   = cnt + 1'b1;
        rd_idx    = start_ptr + rd_addr;

        state_nxt = state;
        if (arm) begin
            state_nxt = S_FILL;
        end else if (accept) begin
            case (state)
                S_FILL:  if (cnt_inc == PRE_CNT) state_nxt = S_ARMED;
                S_ARMED: if (trig_hit) state_nxt = (POST_CNT == CNT_W'(1)) ? S_DONE : S_POST;
                S_POST:  if (cnt_inc == POST_CNT) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            armed     <= (state_nxt == S_ARMED);
            triggered <= (state_nxt == S_POST) || (state_nxt == S_DONE);
            done      <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            start_ptr  <= '0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (arm) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
        end else if (accept) begin
            wr_ptr     <= wr_ptr + 1'b1;
            prev       <= sample_in;
            prev_valid <= 1'b1;
            if (trig_hit) begin
                // trigger sample lands at trace index PRE
                start_ptr <= wr_ptr - PRE_OFS;
                cnt       <= CNT_W'(1);
            end else if (state == S_FILL) begin
                cnt <= (cnt_inc == PRE_CNT) ? '0 : cnt_inc;
            end else if (state == S_POST) begin
                cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= sample_in;
    end

    // read stage: registered, old data on a same-slot write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= mem[rd_idx];
    end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: vector table, directed corner sequences and a
// randomized run, all checked against an acquisition-level reference model.
`timescale 1ns/1ps
module tb_scope_trigger_capture;

    localparam int DEPTH = 64;
    localparam int PRE   = 16;
    localparam int POSTN = DEPTH - PRE;

    logic       clk = 0, rst_n = 0, ena = 0, sample_valid = 0;
    logic       trig_rising = 1, force_trig = 0, arm = 0;
    logic [7:0] sample_in = 0, trig_level = 0;
    logic [5:0] rd_addr = 0;
    logic [7:0] rd_data;
    logic       armed, triggered, done;

    scope_trigger_capture #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(6), .PRE(PRE)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
        .sample_valid(sample_valid), .trig_level(trig_level), .trig_rising(trig_rising),
        .force_trig(force_trig), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
        .armed(armed), .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the list of samples accepted since the last arm, the index
    // of the trigger within it, and a sample-slot picture of the memory.
    bit         m_active;
    byte unsigned m_hist[$];
    int         m_trig;
    int         m_start;
    logic [7:0] mm[DEPTH];
    bit         mk[DEPTH];

    function automatic bit m_done();
        return (m_trig >= 0) && ((m_hist.size() - m_trig) >= POSTN);
    endfunction
    function automatic bit m_armed();
        return m_active && (m_hist.size() >= PRE) && (m_trig < 0);
    endfunction

    task automatic m_reset();
        m_active = 0;
        m_hist.delete();
        m_trig  = -1;
        m_start = 0;
    endtask

    task automatic step(input bit a, input bit e, input bit v, input logic [7:0] s,
                        input bit f, input logic [7:0] lvl, input bit rise, input logic [5:0] ra);
        int slot, n;
        bit rk, hit;
        logic [7:0] rexp;
        byte unsigned p;
        arm = a; ena = e; sample_valid = v; sample_in = s;
        force_trig = f; trig_level = lvl; trig_rising = rise; rd_addr = ra;
        slot = (m_start + int'(ra)) % DEPTH;
        rk   = mk[slot];
        rexp = mm[slot];
        n    = m_hist.size();
        if (a) begin
            m_active = 1;
            m_hist.delete();
            m_trig = -1;
        end else if (e && v && m_active && !m_done()) begin
            if (m_armed()) begin
                p   = m_hist[n-1];
                hit = f || (rise ? (p < lvl && s >= lvl) : (p >= lvl && s < lvl));
                if (hit) begin
                    m_trig  = n;
                    m_start = (n - PRE) % DEPTH;
                end
            end
            mm[n % DEPTH] = s;
            mk[n % DEPTH] = 1;
            m_hist.push_back(s);
        end
        @(posedge clk); #1;
        chk("armed", armed, m_armed());
        chk("triggered", triggered, m_trig >= 0);
        chk("done", done, m_done());
        if (rk) chk("rd_data", rd_data, rexp);
    endtask

    task automatic feed(input logic [7:0] s, input logic [7:0] lvl, input bit rise);
        step(0, 1, 1, s, 0, lvl, rise, 6'd0);
    endtask

    task automatic rd(input logic [5:0] ra);
        step(0, 0, 0, 8'd0, 0, trig_level, trig_rising, ra);
    endtask

    typedef struct {
        string      name;
        int         rep;
        bit         a, e, v, f;
        logic [7:0] s;
        bit         x_armed, x_trig, x_done;
    } vec_t;

    function automatic vec_t mkv(input string nm, input int rep, input bit a, input bit e,
                                 input bit v, input bit f, input logic [7:0] s,
                                 input bit xa, input bit xt, input bit xd);
        vec_t r;
        r.name = nm; r.rep = rep; r.a = a; r.e = e; r.v = v; r.f = f; r.s = s;
        r.x_armed = xa; r.x_trig = xt; r.x_done = xd;
        return r;
    endfunction

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int w, v;
        bit a, e, vv, f;
        logic [7:0] lvl;
        bit rise;

        tbl[0] = mkv("tbl_arm",    1,  1, 1, 0, 0, 8'd5, 0, 0, 0);
        tbl[1] = mkv("tbl_fill",   16, 0, 1, 1, 0, 8'd5, 1, 0, 0);
        tbl[2] = mkv("tbl_gated",  5,  0, 0, 1, 1, 8'd5, 1, 0, 0);
        tbl[3] = mkv("tbl_force",  1,  0, 1, 1, 1, 8'd5, 0, 1, 0);
        tbl[4] = mkv("tbl_post",   46, 0, 1, 1, 0, 8'd5, 0, 1, 0);
        tbl[5] = mkv("tbl_last",   1,  0, 1, 1, 0, 8'd5, 0, 1, 1);
        tbl[6] = mkv("tbl_frozen", 3,  0, 1, 1, 1, 8'd9, 0, 1, 1);

        for (int i = 0; i < DEPTH; i++) mk[i] = 0;
        m_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1;

        // ramp, rising at 40
        step(1, 0, 0, 8'd0, 0, 8'd40, 1, 6'd0);
        for (int s = 0; s < 88; s++) begin
            feed(8'(s), 8'd40, 1);
            if (s == 14) chk("ramp_armed_early", armed, 0);
            if (s == 15) chk("ramp_armed", armed, 1);
            if (s == 39) chk("ramp_no_trig", triggered, 0);
            if (s == 40) chk("ramp_trig", triggered, 1);
            if (s == 86) chk("ramp_not_done", done, 0);
            if (s == 87) chk("ramp_done", done, 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(6'(i));
            chk("ramp_rd", rd_data, 24 + i);
        end

        // falling slope at 90
        step(1, 0, 0, 8'd0, 0, 8'd90, 0, 6'd0);
        repeat (20) feed(8'd100, 8'd90, 0);
        for (int k = 0; k < 100 && !done; k++) begin
            feed(8'(99 - k), 8'd90, 0);
            if (99 - k == 90) chk("fall_no_trig", triggered, 0);
            if (99 - k == 89) chk("fall_trig", triggered, 1);
        end
        chk("fall_done", done, 1);
        rd(6'd16); chk("fall_rd16", rd_data, 89);
        rd(6'd15); chk("fall_rd15", rd_data, 90);
        rd(6'd63); chk("fall_rd63", rd_data, 42);

        // long wait in ARMED: pointer wraps several times before the trigger
        step(1, 0, 0, 8'd0, 0, 8'd30, 1, 6'd0);
        repeat (200) feed(8'd10, 8'd30, 1);
        chk("wrap_no_trig", triggered, 0);
        feed(8'd50, 8'd30, 1);
        chk("wrap_trig", triggered, 1);
        repeat (POSTN - 1) feed(8'd60, 8'd30, 1);
        chk("wrap_done", done, 1);
        for (int i = 0; i <= PRE; i++) begin
            rd(6'(i));
            chk("wrap_rd", rd_data, (i < PRE) ? 10 : 50);
        end

        // force and ena gating, table driven
        for (int i = 0; i < 7; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                step(tbl[i].a, tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].f, 8'd200, 1, 6'(r));
            chk({tbl[i].name, "_armed"}, armed, tbl[i].x_armed);
            chk({tbl[i].name, "_trig"}, triggered, tbl[i].x_trig);
            chk({tbl[i].name, "_done"}, done, tbl[i].x_done);
        end

        // restart mid-POST, arm colliding with a sample
        step(1, 0, 0, 8'd0, 0, 8'd200, 1, 6'd0);
        repeat (PRE) feed(8'd5, 8'd200, 1);
        step(0, 1, 1, 8'd5, 1, 8'd200, 1, 6'd0);
        chk("rst_seq_trig", triggered, 1);
        repeat (5) feed(8'd5, 8'd200, 1);
        step(1, 1, 1, 8'd77, 0, 8'd200, 1, 6'd0);
        chk("restart_trig", triggered, 0);
        chk("restart_armed", armed, 0);
        repeat (PRE - 1) feed(8'd5, 8'd200, 1);
        chk("restart_fill", armed, 0);
        feed(8'd5, 8'd200, 1);
        chk("restart_armed_again", armed, 1);

        // asynchronous reset mid-ARMED
        #2 rst_n = 0;
        #1;
        chk("async_armed", armed, 0);
        chk("async_triggered", triggered, 0);
        chk("async_done", done, 0);
        chk("async_rd_data", rd_data, 0);
        m_reset();
        #1 rst_n = 1;
        repeat (20) feed(8'd5, 8'd200, 1);
        chk("post_rst_idle", armed, 0);

        // read/write collision and read latency (start_ptr is 0 after reset)
        step(1, 0, 0, 8'd0, 0, 8'd255, 1, 6'd0);
        for (int i = 0; i < 70; i++) feed(8'(i), 8'd255, 1);
        step(0, 1, 1, 8'd70, 0, 8'd255, 1, 6'd6);
        chk("collision_old", rd_data, 6);
        rd(6'd6);  chk("collision_new", rd_data, 70);
        rd(6'd20); chk("latency_20", rd_data, 20);
        rd_addr = 6'd30;
        #2;
        chk("latency_hold", rd_data, 20);
        rd(6'd30); chk("latency_30", rd_data, 30);

        // randomized run
        w = 128; lvl = 8'd128; rise = 1;
        step(1, 0, 0, 8'd0, 0, lvl, rise, 6'd0);
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) begin
                lvl  = 8'($urandom_range(60, 200));
                rise = 1'($urandom_range(0, 1));
            end
            w = w + int'($urandom_range(0, 60)) - 30;
            if (w < 0) w = 0;
            if (w > 255) w = 255;
            v  = w;
            a  = ($urandom_range(0, 299) == 0) || (m_done() && $urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 9) != 0);
            vv = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 99) == 0);
            step(a, e, vv, 8'(v), f, lvl, rise, 6'($urandom_range(0, DEPTH - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scope_trigger_capture.md
# scope_trigger_capture

Sample-capture stage feeding the scope display path of `tt_um_dummy`. Accepts 8-bit samples with a valid strobe and keeps a circular pre-trigger history. It detects a level-crossing trigger with selectable slope, then captures a fixed post-trigger window and freezes the buffer. The downstream VGA renderer reads the frozen trace by trigger-relative address with one-cycle latency.

## Interface
- `DEPTH`, 64: buffer length in samples; power of two.
- `ADDR_W`, 6: log2(DEPTH).
- `PRE`, 16: pre-trigger sample count; 1 ≤ PRE ≤ DEPTH-1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ena`  in  1  design enable; when low, `sample_valid` is ignored.
- `sample_in`  in  8  unsigned sample.
- `sample_valid`  in  1  one-cycle strobe qualifying `sample_in`.
- `trig_level`  in  8  unsigned trigger threshold.
- `trig_rising`  in  1  1 = rising slope, 0 = falling slope.
- `force_trig`  in  1  level; treat the next valid sample in ARMED as a trigger.
- `arm`  in  1  one-cycle pulse; starts or restarts an acquisition.
- `rd_addr`  in  ADDR_W  trigger-relative read index; 0 = oldest pre-trigger sample.
- `rd_data`  out  8  registered read data.
- `armed`  out  1  high in ARMED.
- `triggered`  out  1  high in POST and DONE.
- `done`  out  1  high in DONE; the buffer is frozen.

## Operation
- States: IDLE, FILL, ARMED, POST, DONE.
- IDLE: no writes. `arm` -> FILL. `wr_ptr` = 0, `cnt` = 0, `prev_valid` = 0.
- Accepted sample (`ena & sample_valid` in FILL, ARMED or POST) is handled as follows:
  - write `mem[wr_ptr]`;
  - `wr_ptr` += 1 (mod DEPTH);
  - `prev` <= `sample_in`;
  - `prev_valid` <= 1.
- FILL: counts accepted samples. After the PRE-th sample -> ARMED. No trigger evaluation in FILL.
- ARMED: every accepted sample is evaluated for a trigger.
  - Rising: `prev_valid & prev < trig_level & sample_in >= trig_level`.
  - Falling: `prev_valid & prev >= trig_level & sample_in < trig_level`.
  - `force_trig` high: trigger on this sample regardless of level.
  - On trigger: the triggering sample is written normally; `start_ptr` <= `wr_ptr` - PRE (mod DEPTH); `cnt` <= 1; -> POST.
  - The oldest history keeps being overwritten while waiting; only the latest PRE samples before the trigger are guaranteed.
- POST: counts accepted samples. When `cnt` reaches DEPTH-PRE (including the trigger sample) -> DONE.
- DONE: no writes; the buffer stays frozen until the next `arm`.
- `arm` in any state (including mid-FILL, ARMED or POST) restarts: counters cleared, `prev_valid` = 0, -> FILL.
  - `arm` in the same cycle as an accepted sample: the arm wins and that sample is discarded.
- Read path: `rd_data` <= `mem[(start_ptr + rd_addr) mod DEPTH]` every cycle, regardless of state.
  - Read and write to the same address in one cycle return the old data.
  - Reads outside DONE are legal but undefined in content.
- `ena` low: no sample is accepted. State, counters and `arm` handling are unaffected.

## Timing
- Reset values:
  - state = IDLE;
  - `armed` = `triggered` = `done` = 0;
  - `rd_data` = 0;
  - `wr_ptr` = `start_ptr` = `cnt` = 0;
  - `prev` = 0, `prev_valid` = 0.
- Memory contents are not reset.
- Reset asserted mid-acquisition returns the block to IDLE immediately (asynchronous); the next `arm` is required.
- Status outputs are registered from state and change in the cycle after the causing edge.
  - The trigger sample at edge N: `triggered` = 1 from N+1.
  - The last post sample at edge M: `done` = 1 from M+1, and `triggered` stays 1.
- Read latency: `rd_addr` at edge K -> `rd_data` valid after edge K+1. Back-to-back reads run one per cycle.
- Trace ordering: index PRE holds the trigger sample; index DEPTH-1 holds the last post-trigger sample.
- Pointer arithmetic is ADDR_W bits and wraps silently.
- The minimum acquisition is PRE + 1 + (DEPTH-PRE-1) accepted samples when the trigger comes immediately after FILL.

## Test plan
- Ramp trigger: reset, `arm`, feed 0,1,2,…, level 40, rising, defaults.
  - Trigger occurs on sample 40.
  - After sample 87, `done` = 1.
  - `rd_addr` 0..63 returns 24..87; `rd_addr` 16 returns 40.
- Falling slope: feed 100 ×20 then 99,98,…; level 90, `trig_rising` = 0.
  - Trigger occurs on sample 89 (`prev` = 90).
  - `rd_data` at `rd_addr` 16 = 89, and at `rd_addr` 15 = 90.
- Wrap-around: feed 200 samples of 10 while ARMED (no crossing), then 50, level 30.
  - Trigger occurs on 50.
  - `rd_addr` 0..15 return 10, `rd_addr` 16 returns 50; correct through the pointer wrap.
- Force and gating: ARMED on a flat 5 with `force_trig` = 1; pulse `sample_valid` while `ena` = 0.
  - No sample is accepted while `ena` = 0.
  - The first sample with `ena` = 1 triggers.
  - `done` follows 47 further samples.
- Restart and reset: `arm` pulsed mid-POST -> FILL, `triggered` = 0 next cycle, PRE samples needed again before ARMED. `rst_n` low mid-ARMED -> all outputs 0 asynchronously; with no `arm`, samples are ignored.
- Collision and latency: in ARMED, `rd_addr` targets the `wr_ptr` slot during a write -> the old value is returned. Verify `rd_data` updates exactly one cycle after a `rd_addr` change.
